// File: rtl/hdc_dot_sequencer_if.sv
// Bundle between the HDC dot-product sequencer and its product stream,
// FP16 accumulator, weight-memory address generator and result consumer.
interface hdc_dot_sequencer_if #(
    parameter int DIM         = 1024,
    parameter int NUM_CLASSES = 10,
    parameter int WIDTH       = 16,
    parameter int EW          = (DIM > 1) ? $clog2(DIM) : 1,
    parameter int CW          = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1
);
    logic             start;
    logic             abort;
    logic             prod_valid;
    logic             prod_ready;
    logic [WIDTH-1:0] prod_data;
    logic [WIDTH-1:0] acc_din;
    logic             acc_en;
    logic             acc_clear;
    logic [WIDTH-1:0] acc_dout;
    logic [CW-1:0]    class_idx;
    logic [EW-1:0]    elem_idx;
    logic             busy;
    logic             score_valid;
    logic [WIDTH-1:0] score_out;
    logic             done;
    logic [CW-1:0]    best_class;
    logic [WIDTH-1:0] best_score;

    modport master (
        input  start, abort, prod_valid, prod_data, acc_dout,
        output prod_ready, acc_din, acc_en, acc_clear, class_idx, elem_idx,
               busy, score_valid, score_out, done, best_class, best_score
    );

    modport slave (
        output start, abort, prod_valid, prod_data, acc_dout,
        input  prod_ready, acc_din, acc_en, acc_clear, class_idx, elem_idx,
               busy, score_valid, score_out, done, best_class, best_score
    );
endinterface

// File: rtl/hdc_dot_sequencer.sv
// Sequences an FP16 accumulator through NUM_CLASSES dot products of DIM
// elements each, capturing every class score and tracking the running argmax.
module hdc_dot_sequencer #(
    parameter int DIM         = 1024,
    parameter int NUM_CLASSES = 10,
    parameter int WIDTH       = 16
) (
    input logic                clk,
    input logic                rst_n,
    hdc_dot_sequencer_if.master bus
);
    localparam int EW = (DIM > 1) ? $clog2(DIM) : 1;
    localparam int CW = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1;
    localparam logic [EW-1:0]    ELEM_LAST  = EW'(DIM - 1);
    localparam logic [CW-1:0]    CLASS_LAST = CW'(NUM_CLASSES - 1);
    localparam logic [WIDTH-1:0] NEG_INF    = WIDTH'(16'hFC00);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_ACCUM,
        S_CAPTURE,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    class_q, class_d;
    logic [EW-1:0]    elem_q, elem_d;
    logic [CW-1:0]    best_class_q, best_class_d;
    logic [WIDTH-1:0] best_score_q, best_score_d;
    logic             abort_clr_q, abort_clr_d;
    logic             accept;

    function automatic logic is_nan(input logic [15:0] x);
        return (x[14:10] == 5'h1F) && (x[9:0] != '0);
    endfunction

    // Strict FP16 greater-than for non-NaN operands; +0 and -0 are equal.
    function automatic logic fp16_gt(input logic [15:0] a, input logic [15:0] b);
        if (a[15] != b[15])
            return !a[15] && ((a[14:0] != '0) || (b[14:0] != '0));
        else if (!a[15])
            return a[14:0] > b[14:0];
        else
            return a[14:0] < b[14:0];
    endfunction

    assign accept = (state_q == S_ACCUM) && bus.prod_valid;

    always_comb begin
        state_d      = state_q;
        class_d      = class_q;
        elem_d       = elem_q;
        best_class_d = best_class_q;
        best_score_d = best_score_q;
        abort_clr_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d      = S_CLEAR;
                    best_score_d = NEG_INF;
                    best_class_d = '0;
                    class_d      = '0;
                    elem_d       = '0;
                end
            end
            S_CLEAR: state_d = S_ACCUM;
            S_ACCUM: begin
                if (accept) begin
                    if (elem_q == ELEM_LAST) begin
                        elem_d  = '0;
                        state_d = S_CAPTURE;
                    end else begin
                        elem_d = elem_q + 1'b1;
                    end
                end
            end
            S_CAPTURE: begin
                if (!is_nan(bus.acc_dout) && fp16_gt(bus.acc_dout, best_score_q)) begin
                    best_score_d = bus.acc_dout;
                    best_class_d = class_q;
                end
                if (class_q == CLASS_LAST) begin
                    state_d = S_DONE;
                end else begin
                    class_d = class_q + 1'b1;
                    state_d = S_ACCUM;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                class_d = '0;
            end
            default: state_d = S_IDLE;
        endcase

        // Abort overrides whatever the state decided, including a pending argmax update.
        if (bus.abort && (state_q != S_IDLE)) begin
            state_d      = S_IDLE;
            class_d      = '0;
            elem_d       = '0;
            best_class_d = best_class_q;
            best_score_d = best_score_q;
            abort_clr_d  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            class_q      <= '0;
            elem_q       <= '0;
            best_class_q <= '0;
            best_score_q <= NEG_INF;
            abort_clr_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            class_q      <= class_d;
            elem_q       <= elem_d;
            best_class_q <= best_class_d;
            best_score_q <= best_score_d;
            abort_clr_q  <= abort_clr_d;
        end
    end

    assign bus.prod_ready  = (state_q == S_ACCUM);
    assign bus.acc_en      = accept;
    assign bus.acc_din     = bus.prod_data;
    assign bus.acc_clear   = (state_q == S_CLEAR) || (state_q == S_CAPTURE) || abort_clr_q;
    assign bus.busy        = (state_q != S_IDLE);
    assign bus.score_valid = (state_q == S_CAPTURE);
    assign bus.score_out   = bus.acc_dout;
    assign bus.done        = (state_q == S_DONE);
    assign bus.class_idx   = class_q;
    assign bus.elem_idx    = elem_q;
    assign bus.best_class  = best_class_q;
    assign bus.best_score  = best_score_q;
endmodule
